crc_stream: RTL and testbench

Parametrised streaming CRC engine for framed data. Generalises the fixed 32-bit CRC-32 accumulator to configurable data width, polynomial, init, reflection and output XOR. It adds frame delimiting, partial last beats via byte keep, valid/ready flow control, a registered result strobe and an optional residue check. It sits on packet datapaths between a framer or DMA and the link or checker logic.

---
 rtl/crc_stream.sv | 134 +++++++++++++
 tb/tb_crc_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream.sv
// crc_stream: parametrised streaming CRC engine for framed data.
// Accepts one beat per cycle with valid/ready, honours byte keep on the last
// beat, and strobes the final CRC one cycle after the frame closes.
// Optional build macro CRC_CHECK_EN adds the residue comparator behind crc_ok.
module crc_stream #(
  parameter int          DATA_W  = 32,
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic [CRC_W-1:0]    crc_out,
  output logic                crc_valid,
  output logic                crc_ok,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  localparam logic [CRC_W-1:0] POLY_N = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] POLY_R = bit_rev(POLY_N);
  localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_T  = XOR_OUT[CRC_W-1:0];

  // One byte through the register, eight shift steps unrolled.
  // Reflected mode feeds the byte into the low end and shifts right;
  // normal mode feeds it into the high end and shifts left.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                input logic [7:0] b);
    logic [CRC_W-1:0] r;
    r = c;
    if (REFLECT) begin
      r[7:0] = r[7:0] ^ b;
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
    end else begin
      r[CRC_W-1 -: 8] = r[CRC_W-1 -: 8] ^ b;
      for (int k = 0; k < 8; k++) r = r[CRC_W-1] ? ((r << 1) ^ POLY_N) : (r << 1);
    end
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_step;
  logic [CRC_W-1:0] crc_out_q;
  logic [CRC_W-1:0] crc_fin;
  logic             accept;
  logic             out_fire;

  // Next state and handshake; clr forces IDLE and blocks acceptance.
  always_comb begin
    state_d  = state_q;
    in_ready = !rst && !clr && (state_q != S_OUT);
    accept   = in_valid && in_ready;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: if (accept) state_d = in_last ? S_OUT : S_ACC;
        S_OUT:         state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  // Advance the register over the enabled bytes of the current beat, byte 0 first.
  always_comb begin
    crc_step = crc_q;
    for (int i = 0; i < NB; i++) begin
      if (!in_last || in_keep[i]) crc_step = crc_byte(crc_step, in_data[8*i +: 8]);
    end
    if (clr || state_q == S_OUT) crc_d = INIT_T;
    else if (accept)             crc_d = crc_step;
    else                         crc_d = crc_q;
  end

  // The result is presented during OUT unless aborted; otherwise the last one holds.
  assign out_fire  = (state_q == S_OUT) && !clr && !rst;
  assign crc_fin   = crc_q ^ XOR_T;
  assign crc_out   = out_fire ? crc_fin : crc_out_q;
  assign crc_valid = out_fire;
  assign busy      = (state_q != S_IDLE);

  // State, CRC register and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      crc_q     <= INIT_T;
      crc_out_q <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      if (out_fire) crc_out_q <= crc_fin;
    end
  end

`ifdef CRC_CHECK_EN
  localparam logic [CRC_W-1:0] RES_T = RESIDUE[CRC_W-1:0];
  logic ok_q;
  logic ok_now;

  assign ok_now = (crc_q == RES_T);
  assign crc_ok = out_fire ? ok_now : ok_q;

  // Residue verdict held alongside the held CRC result.
  always_ff @(posedge clk) begin
    if (rst)           ok_q <= 1'b0;
    else if (out_fire) ok_q <= ok_now;
  end
`else
  // Residue is only meaningful when the checker is built.
  logic unused_residue;
  assign unused_residue = ^RESIDUE;
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: a CRC-32 instance (defaults) and a
// CRC-16/CCITT-FALSE instance with byte-wide input.
module tb_crc_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr;
  logic        in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic [31:0] crc_out;
  logic        crc_valid, crc_ok, busy;

  logic        b_valid, b_last, b_ready;
  logic [7:0]  b_data;
  logic [0:0]  b_keep;
  logic [15:0] b_crc_out;
  logic        b_crc_valid, b_crc_ok, b_busy;

  int checks = 0;
  int failures = 0;

  crc_stream dut32 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .crc_out(crc_out), .crc_valid(crc_valid), .crc_ok(crc_ok), .busy(busy)
  );

  crc_stream #(
    .DATA_W(8), .CRC_W(16), .POLY(32'h00001021), .INIT(32'h0000FFFF),
    .XOR_OUT(32'h0), .REFLECT(1'b0), .RESIDUE(32'h0)
  ) dut16 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_keep(b_keep), .in_last(b_last),
    .crc_out(b_crc_out), .crc_valid(b_crc_valid), .crc_ok(b_crc_ok), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bitwise reflected CRC-32 reference, one message bit at a time.
  function automatic logic [31:0] ref32(input logic [7:0] q[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ q[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // Present one beat after 'gap' idle cycles; returns at the negedge after acceptance.
  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input int gap, output int waited);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    waited   = 0;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_bytes32(input logic [7:0] q[$]);
    int n, w;
    logic [31:0] d;
    logic [3:0] k;
    n = q.size();
    for (int i = 0; i < n; i += 4) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < n) begin
          d[8*j +: 8] = q[i+j];
          k[j] = 1'b1;
        end
      end
      beat32(d, k, (i + 4 >= n), 0, w);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg[$];
    logic [7:0] res[$];
    logic [7:0] q[$];
    logic [31:0] last_exp, d;
    logic [3:0] k;
    int w, nb, n;
    logic l;

    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst = 1'b1; clr = 1'b0;
    in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_keep = 1'b1; b_last = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_crc_out", crc_out, 32'h0);
    chk("rst_valid", 32'(crc_valid), 32'd0);
    chk("rst_ok", 32'(crc_ok), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst16_crc_out", 32'(b_crc_out), 32'h0);
    chk("rst16_ready", 32'(b_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // CRC-32 check string, partial last beat
    send_bytes32(msg);
    chk("c32_crc", crc_out, 32'hCBF43926);
    chk("c32_valid", 32'(crc_valid), 32'd1);
    chk("c32_busy_out", 32'(busy), 32'd1);
    chk("c32_ready_out", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("c32_strobe_one", 32'(crc_valid), 32'd0);
    chk("c32_hold", crc_out, 32'hCBF43926);
    chk("c32_idle_busy", 32'(busy), 32'd0);

    // CRC-16/CCITT-FALSE, MSB-first, byte-wide
    for (int i = 0; i < 9; i++) begin
      b_data  = msg[i];
      b_last  = (i == 8);
      b_valid = 1'b1;
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("c16_crc", 32'(b_crc_out), 32'h29B1);
    chk("c16_valid", 32'(b_crc_valid), 32'd1);
    @(negedge clk);
    chk("c16_strobe_one", 32'(b_crc_valid), 32'd0);

    // Back-to-back single-byte frames, in_valid held high
    beat32(32'h00000000, 4'b0001, 1'b1, 0, w);
    chk("b2b_zero", crc_out, 32'hD202EF8D);
    beat32(32'h00000061, 4'b0001, 1'b1, 0, w);
    chk("b2b_bubble", 32'(w), 32'd1);
    chk("b2b_a", crc_out, 32'hE8B7BE43);
    chk("b2b_a_valid", 32'(crc_valid), 32'd1);

    // Frame carrying its own CRC: register lands on the residue
    res = msg;
    res.push_back(8'h26); res.push_back(8'h39); res.push_back(8'hF4); res.push_back(8'hCB);
    send_bytes32(res);
    chk("resid_crc", crc_out, 32'h2144DF1C);
`ifdef CRC_CHECK_EN
    chk("resid_ok", 32'(crc_ok), 32'd1);
    @(negedge clk);
    chk("resid_ok_hold", 32'(crc_ok), 32'd1);
`else
    chk("resid_ok_off", 32'(crc_ok), 32'd0);
    @(negedge clk);
`endif
    res[0] = 8'h30;
    last_exp = ref32(res);
    send_bytes32(res);
    chk("resid_bad_crc", crc_out, last_exp);
    chk("resid_bad_ok", 32'(crc_ok), 32'd0);
    @(negedge clk);

    // clr after two beats, then a clean frame
    beat32(32'h11223344, 4'hF, 1'b0, 0, w);
    beat32(32'h55667788, 4'hF, 1'b0, 0, w);
    clr = 1'b1;
    #1;
    chk("clr_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("clr_no_strobe", 32'(crc_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_crc_kept", crc_out, last_exp);
    clr = 1'b0;
    send_bytes32(msg);
    chk("clr_then_crc", crc_out, 32'hCBF43926);
    chk("clr_then_valid", 32'(crc_valid), 32'd1);

    // clr landing in OUT suppresses the strobe and the update
    @(negedge clk);
    beat32(32'h00000061, 4'b0001, 1'b1, 0, w);
    clr = 1'b1;
    #1;
    chk("clr_out_valid", 32'(crc_valid), 32'd0);
    chk("clr_out_crc", crc_out, 32'hCBF43926);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_out_held", crc_out, 32'hCBF43926);

    // rst after two beats
    beat32(32'hA5A5A5A5, 4'hF, 1'b0, 0, w);
    beat32(32'h5A5A5A5A, 4'hF, 1'b0, 0, w);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", 32'(in_ready), 32'd0);
    chk("mrst_crc_out", crc_out, 32'h0);
    chk("mrst_valid", 32'(crc_valid), 32'd0);
    chk("mrst_ok", 32'(crc_ok), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    send_bytes32(msg);
    chk("mrst_then_crc", crc_out, 32'hCBF43926);

    // Last beat with keep = 0 contributes nothing
    @(negedge clk);
    beat32(32'h34333231, 4'hF, 1'b0, 0, w);
    beat32(32'hDEADBEEF, 4'h0, 1'b1, 0, w);
    q = '{8'h31, 8'h32, 8'h33, 8'h34};
    chk("keep0_crc", crc_out, ref32(q));
    chk("keep0_valid", 32'(crc_valid), 32'd1);

    // Random frames with idle gaps and random final keep
    for (int f = 0; f < 100; f++) begin
      nb = $urandom_range(1, 16);
      q.delete();
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        l = (b == nb - 1);
        n = l ? $urandom_range(0, 4) : 4;
        k = 4'((1 << n) - 1);
        for (int j = 0; j < n; j++) q.push_back(d[8*j +: 8]);
        beat32(d, k, l, $urandom_range(0, 2), w);
      end
      chk($sformatf("rand_crc_%0d", f), crc_out, ref32(q));
      chk($sformatf("rand_valid_%0d", f), 32'(crc_valid), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
